// File: rtl/pc_unit_pkg.sv
// ============================================================================
// Module  : pc_unit_pkg
// Purpose : Shared next-PC select encodings for the PC unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_RET    = 2'd3
  } sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module  : pc_ras
// Purpose : Circular return-address stack; overflow overwrites the oldest
//           entry, and overflow or underflow sets a sticky error flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [PW-1:0] w_ptr_dec;

  assign w_ptr_dec = ptr_q - C_PTR_ONE;
  assign top       = mem_q[w_ptr_dec];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == C_DEPTH);
  assign err       = err_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      // When full, ptr already addresses the oldest entry, so the write recycles it
      ptr_d = ptr_q + C_PTR_ONE;
      if (full) err_d = 1'b1;
      else      cnt_d = cnt_q + C_CNT_ONE;
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        ptr_d = w_ptr_dec;
        cnt_d = cnt_q - C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module  : pc_unit
// Purpose : Program counter register with next-PC select (seq/branch/jump/
//           return) and an integrated return-address stack.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               PC_W      = 16,
  parameter int               OFF_W     = 8,
  parameter int               INC       = 1,
  parameter int               RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic             br_taken,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  jmp_tgt,
  input  logic             call,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [PC_W-1:0] C_INC = PC_W'(INC);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_br_ext;
  logic [PC_W-1:0] w_ras_top;
  logic            w_push, w_pop;

  assign w_pc_seq = pc_q + C_INC;
  assign w_br_ext = PC_W'($signed(br_off));
  assign w_push   = (sel == SEL_JUMP) && call && !stall;
  assign w_pop    = (sel == SEL_RET) && !stall;

  always_comb begin
    pc_d = w_pc_seq;
    unique case (sel_e'(sel))
      SEL_SEQ:    pc_d = w_pc_seq;
      SEL_BRANCH: pc_d = br_taken ? (pc_q + w_br_ext) : w_pc_seq;
      SEL_JUMP:   pc_d = jmp_tgt;
      SEL_RET:    pc_d = ras_empty ? w_pc_seq : w_ras_top;
      default:    pc_d = w_pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         pc_q <= RESET_VEC;
    else if (!stall) pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_seq),
    .top   (w_ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .err   (ras_err)
  );

endmodule

`default_nettype wire
